// File: rtl/cmd_stream_assembler_pkg.sv
// Shared constants and byte-position state for assembling 32-bit commands
// from a big-endian UART byte stream.
package cmd_stream_assembler_pkg;

   localparam int CMD_WIDTH = 32;
   localparam int CMD_BYTES = 4;
   localparam int BYTE_W    = CMD_WIDTH / CMD_BYTES;

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } byte_state_t;

   function automatic byte_state_t next_byte_state(input byte_state_t s);
      case (s)
         B0:      return B1;
         B1:      return B2;
         B2:      return B3;
         default: return B0;
      endcase
   endfunction

endpackage

// File: rtl/cmd_stream_assembler_if.sv
// UART byte side and AXI-stream command side of the assembler in one bundle;
// slave is the assembler's view, master is the environment's view.
interface cmd_stream_assembler_if;
   import cmd_stream_assembler_pkg::*;

   logic                 rx_valid_i;
   logic                 rx_busy_i;
   logic [BYTE_W-1:0]    rx_data_i;
   logic                 rx_rd_o;
   logic                 cmd_axis_tvalid_o;
   logic                 cmd_axis_tready_i;
   logic [CMD_WIDTH-1:0] cmd_axis_tdata_o;

   modport slave (
      input  rx_valid_i, rx_busy_i, rx_data_i, cmd_axis_tready_i,
      output rx_rd_o, cmd_axis_tvalid_o, cmd_axis_tdata_o
   );

   modport master (
      output rx_valid_i, rx_busy_i, rx_data_i, cmd_axis_tready_i,
      input  rx_rd_o, cmd_axis_tvalid_o, cmd_axis_tdata_o
   );

endinterface

// File: rtl/cmd_stream_assembler_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    pop,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       level_nxt;
   logic              push_ok;
   logic              pop_ok;

   // A push while full is dropped even if a pop frees a slot in the same cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      level_nxt = level;
      case ({push_ok, pop_ok})
         2'b10:   level_nxt = level + (AW+1)'(1);
         2'b01:   level_nxt = level - (AW+1)'(1);
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
         full  <= (level_nxt == (AW+1)'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Storage is never cleared, so an empty FIFO presents zero rather than stale data.
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cmd_stream_assembler.sv
// Packs UART bytes big-endian into 32-bit command words, buffers them in a
// small FIFO toward an AXI-stream consumer, and drops stale partial words.
module cmd_stream_assembler
   import cmd_stream_assembler_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic                         clk,
   input  logic                         reset_i,
   cmd_stream_assembler_if.slave        stream,
   output logic                         resync_o,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   byte_state_t                 state;
   logic [CW-1:0]               tmo_cnt;
   logic [CMD_WIDTH-BYTE_W-1:0] partial;
   logic                        offered;
   logic                        accept;
   logic                        push;
   logic                        full;
   logic                        empty;

   // Only the closing byte needs a free slot; earlier bytes are always taken.
   assign stream.rx_rd_o = !(state == B3 && full);
   assign offered        = stream.rx_valid_i && !stream.rx_busy_i;
   assign accept         = offered && stream.rx_rd_o;
   assign push           = accept && (state == B3);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state    <= B0;
         tmo_cnt  <= '0;
         resync_o <= 1'b0;
      end else begin
         resync_o <= 1'b0;
         if (accept) begin
            state   <= next_byte_state(state);
            tmo_cnt <= '0;
         end else if (state == B0) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state    <= B0;
            tmo_cnt  <= '0;
            resync_o <= 1'b1;
         end else if (!offered) begin
            tmo_cnt <= tmo_cnt + CW'(1);
         end
      end
   end

   // Earlier bytes shift toward the MSBs; a discarded word is fully overwritten
   // by the next three bytes, so it needs no explicit clear.
   always_ff @(posedge clk) begin
      if (accept && state != B3)
         partial <= {partial[CMD_WIDTH-2*BYTE_W-1:0], stream.rx_data_i};
   end

   sync_fifo #(
      .DATA_W (CMD_WIDTH),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset_i),
      .push    (push),
      .wr_data ({partial, stream.rx_data_i}),
      .pop     (stream.cmd_axis_tvalid_o && stream.cmd_axis_tready_i),
      .rd_data (stream.cmd_axis_tdata_o),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level_o)
   );

   assign stream.cmd_axis_tvalid_o = !empty;

endmodule

// File: tb/tb_cmd_stream_assembler.sv
// Directed bench for cmd_stream_assembler: single word, back-pressure,
// inter-byte timeout, asynchronous reset and random-ready streaming.
module tb_cmd_stream_assembler;
   import cmd_stream_assembler_pkg::*;

   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 100;
   localparam int LW             = $clog2(FIFO_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          resync_o;
   logic [LW-1:0] fifo_level_o;

   cmd_stream_assembler_if stream ();

   cmd_stream_assembler #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .stream       (stream.slave),
      .resync_o     (resync_o),
      .fifo_level_o (fifo_level_o)
   );

   always #5 clk = ~clk;

   int          checks  = 0;
   int          errors  = 0;
   int          beats   = 0;
   int          resyncs = 0;
   logic [31:0] exp_q [$];
   logic        hold_vld = 1'b0;
   logic [31:0] hold_data = '0;
   logic        stream_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard on every beat, stability while stalled.
   initial begin
      logic [31:0] exp_w;
      forever begin
         @(negedge clk);
         if (reset_i) begin
            hold_vld = 1'b0;
         end else begin
            if (resync_o) resyncs++;
            if (hold_vld && stream.cmd_axis_tvalid_o)
               check("tdata_stable", stream.cmd_axis_tdata_o, hold_data);
            if (stream.cmd_axis_tvalid_o && stream.cmd_axis_tready_i) begin
               beats++;
               check("beat_avail", {31'b0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  exp_w = exp_q.pop_front();
                  check("beat_data", stream.cmd_axis_tdata_o, exp_w);
               end
               hold_vld = 1'b0;
            end else if (stream.cmd_axis_tvalid_o) begin
               hold_vld  = 1'b1;
               hold_data = stream.cmd_axis_tdata_o;
            end else begin
               hold_vld = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      stream.rx_data_i  = b;
      stream.rx_valid_i = 1'b1;
      @(negedge clk);
      while (!stream.rx_rd_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!stream.rx_rd_o) check("byte_wait", {31'b0, stream.rx_rd_o}, 32'd1);
      @(posedge clk);
      #1;
      stream.rx_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      exp_q.push_back(w);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (stream.cmd_axis_tvalid_o && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, {31'b0, stream.cmd_axis_tvalid_o}, 32'd0);
   endtask

   initial begin
      reset_i                  = 1'b1;
      stream.rx_valid_i        = 1'b0;
      stream.rx_busy_i         = 1'b0;
      stream.rx_data_i         = '0;
      stream.cmd_axis_tready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;

      check("rst_tvalid", {31'b0, stream.cmd_axis_tvalid_o}, 32'd0);
      check("rst_tdata",  stream.cmd_axis_tdata_o, 32'd0);
      check("rst_level",  32'(fifo_level_o), 32'd0);
      check("rst_rd",     {31'b0, stream.rx_rd_o}, 32'd1);
      check("rst_resync", {31'b0, resync_o}, 32'd0);

      // Single word; a busy UART must not have its byte taken.
      stream.cmd_axis_tready_i = 1'b1;
      stream.rx_data_i  = 8'hFF;
      stream.rx_valid_i = 1'b1;
      stream.rx_busy_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stream.rx_valid_i = 1'b0;
      stream.rx_busy_i  = 1'b0;
      beats = 0;
      exp_q.push_back(32'h12345678);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h78);
      check("t1_latency", {31'b0, stream.cmd_axis_tvalid_o}, 32'd1);
      check("t1_tdata",   stream.cmd_axis_tdata_o, 32'h12345678);
      @(posedge clk);
      #1;
      check("t1_one_cycle", {31'b0, stream.cmd_axis_tvalid_o}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t1_beats", beats, 32'd1);

      // Back-pressure: fifth word stalls on its last byte only.
      stream.cmd_axis_tready_i = 1'b0;
      beats   = 0;
      resyncs = 0;
      for (int k = 0; k < 4; k++) send_word(32'hC0DE0000 | k);
      check("t2_level_full", 32'(fifo_level_o), 32'd4);
      check("t2_head", stream.cmd_axis_tdata_o, 32'hC0DE0000);
      exp_q.push_back(32'h5555AAA5);
      send_byte(8'h55);
      send_byte(8'h55);
      send_byte(8'hAA);
      check("t2_level_b3", 32'(fifo_level_o), 32'd4);
      stream.rx_data_i  = 8'hA5;
      stream.rx_valid_i = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      check("t2_rd_stall",  {31'b0, stream.rx_rd_o}, 32'd0);
      check("t2_level",     32'(fifo_level_o), 32'd4);
      check("t2_no_resync", resyncs, 32'd0);
      check("t2_head_held", stream.cmd_axis_tdata_o, 32'hC0DE0000);
      stream.cmd_axis_tready_i = 1'b1;
      send_byte(8'hA5);
      wait_drain("t2_drain");
      check("t2_beats", beats, 32'd5);
      check("t2_q_empty", 32'(exp_q.size()), 32'd0);

      // Timeout discards AA BB exactly TIMEOUT_CYCLES after the last byte.
      stream.cmd_axis_tready_i = 1'b0;
      beats   = 0;
      resyncs = 0;
      send_word(32'h0BADF00D);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
      #1;
      check("t3_resync_early", {31'b0, resync_o}, 32'd0);
      @(posedge clk);
      #1;
      check("t3_resync_pulse", {31'b0, resync_o}, 32'd1);
      check("t3_fifo_kept", 32'(fifo_level_o), 32'd1);
      @(posedge clk);
      #1;
      check("t3_resync_end", {31'b0, resync_o}, 32'd0);
      check("t3_resync_count", resyncs, 32'd1);
      stream.cmd_axis_tready_i = 1'b1;
      send_word(32'h01020304);
      wait_drain("t3_drain");
      check("t3_beats", beats, 32'd2);
      check("t3_q_empty", 32'(exp_q.size()), 32'd0);
      check("t3_resync_once", resyncs, 32'd1);

      // Asynchronous reset mid-word with two words buffered.
      stream.cmd_axis_tready_i = 1'b0;
      beats = 0;
      send_word(32'hCAFE0001);
      send_word(32'hCAFE0002);
      send_byte(8'hEE);
      send_byte(8'hDD);
      check("t4_level_pre", 32'(fifo_level_o), 32'd2);
      @(negedge clk);
      #2;
      reset_i = 1'b1;
      #1;
      check("t4_tvalid", {31'b0, stream.cmd_axis_tvalid_o}, 32'd0);
      check("t4_level",  32'(fifo_level_o), 32'd0);
      check("t4_tdata",  stream.cmd_axis_tdata_o, 32'd0);
      check("t4_rd",     {31'b0, stream.rx_rd_o}, 32'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      stream.cmd_axis_tready_i = 1'b1;
      send_word(32'hC0FFEE11);
      wait_drain("t4_drain");
      check("t4_beats", beats, 32'd1);
      check("t4_q_empty", 32'(exp_q.size()), 32'd0);

      // Streaming with a randomly toggling ready.
      beats = 0;
      fork
         begin
            for (int i = 0; i < 64; i++) send_word($urandom());
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk);
               #1;
               stream.cmd_axis_tready_i = 1'($urandom_range(0, 1));
            end
         end
      join
      stream.cmd_axis_tready_i = 1'b1;
      wait_drain("t5_drain");
      check("t5_beats", beats, 32'd64);
      check("t5_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
